operand_source_stage: RTL and testbench

Parametrised operand-read stage between issue and execute for NCH issue channels. Each channel drives physical and architectural register-file read addresses. The stage selects operand data from the bypass network, the PRF or the ARF, then registers the result together with the channel payload. Output is held in a two-entry output/skid register pair, so in_ready is a register output and back-pressure does not propagate combinationally. Supports pipeline flush and exports a saturating back-pressure counter.

---
 rtl/operand_source_stage.sv | 126 ++++++++++++
 tb/tb_operand_source_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/operand_source_stage.sv
// operand_source_stage: per-channel operand select (x0 / bypass / PRF / ARF) feeding a
// two-entry output/skid buffer so in_ready is registered and back-pressure never goes combinational.
module operand_source_stage #(
  parameter int NCH    = 8,
  parameter int XLEN   = 64,
  parameter int PREG_W = 7,
  parameter int AREG_W = 5,
  parameter int NBYP   = 4,
  parameter int PAY_W  = 128
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic [NCH-1:0]          in_valid,
  output logic                    in_ready,
  input  logic [NCH*PREG_W-1:0]   in_psrc1,
  input  logic [NCH*PREG_W-1:0]   in_psrc2,
  input  logic [NCH*AREG_W-1:0]   in_asrc1,
  input  logic [NCH*AREG_W-1:0]   in_asrc2,
  input  logic [NCH-1:0]          in_fwd1,
  input  logic [NCH-1:0]          in_fwd2,
  input  logic [NCH*PAY_W-1:0]    in_payload,
  output logic [NCH*PREG_W-1:0]   prf_raddr1,
  output logic [NCH*PREG_W-1:0]   prf_raddr2,
  input  logic [NCH*XLEN-1:0]     prf_rdata1,
  input  logic [NCH*XLEN-1:0]     prf_rdata2,
  output logic [NCH*AREG_W-1:0]   arf_raddr1,
  output logic [NCH*AREG_W-1:0]   arf_raddr2,
  input  logic [NCH*XLEN-1:0]     arf_rdata1,
  input  logic [NCH*XLEN-1:0]     arf_rdata2,
  input  logic [NBYP-1:0]         byp_valid,
  input  logic [NBYP*PREG_W-1:0]  byp_pdst,
  input  logic [NBYP*XLEN-1:0]    byp_data,
  output logic [NCH-1:0]          out_valid,
  input  logic                    out_ready,
  output logic [NCH*XLEN-1:0]     out_d1,
  output logic [NCH*XLEN-1:0]     out_d2,
  output logic [NCH*PAY_W-1:0]    out_payload,
  output logic [31:0]             stall_cnt
);
  logic [NCH*XLEN-1:0]  d1_n, d2_n, m_d1, m_d2, s_d1, s_d2;
  logic [NCH*PAY_W-1:0] m_pay, s_pay;
  logic [NCH-1:0]       m_valid, s_valid;
  logic                 s_full, in_fire, out_fire, s_to_m, load_m, load_s;

  assign prf_raddr1 = in_psrc1;
  assign prf_raddr2 = in_psrc2;
  assign arf_raddr1 = in_asrc1;
  assign arf_raddr2 = in_asrc2;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [PREG_W-1:0] p1, p2;
    logic [XLEN-1:0]   r1, r2;
    assign p1 = in_psrc1[c*PREG_W +: PREG_W];
    assign p2 = in_psrc2[c*PREG_W +: PREG_W];
    always_comb begin
      r1 = in_fwd1[c] ? prf_rdata1[c*XLEN +: XLEN] : arf_rdata1[c*XLEN +: XLEN];
      r2 = in_fwd2[c] ? prf_rdata2[c*XLEN +: XLEN] : arf_rdata2[c*XLEN +: XLEN];
      // descending scan so the lowest matching bypass port wins
      for (int k = NBYP - 1; k >= 0; k--) begin
        if (in_fwd1[c] && byp_valid[k] && byp_pdst[k*PREG_W +: PREG_W] == p1) r1 = byp_data[k*XLEN +: XLEN];
        if (in_fwd2[c] && byp_valid[k] && byp_pdst[k*PREG_W +: PREG_W] == p2) r2 = byp_data[k*XLEN +: XLEN];
      end
      if (in_fwd1[c] ? p1 == '0 : in_asrc1[c*AREG_W +: AREG_W] == '0) r1 = '0;
      if (in_fwd2[c] ? p2 == '0 : in_asrc2[c*AREG_W +: AREG_W] == '0) r2 = '0;
    end
    assign d1_n[c*XLEN +: XLEN] = r1;
    assign d2_n[c*XLEN +: XLEN] = r2;
  end

  assign in_ready = !s_full;
  assign in_fire  = in_ready && |in_valid;
  assign out_fire = |m_valid && out_ready;
  assign s_to_m   = out_fire && s_full;
  assign load_m   = in_fire && (!(|m_valid) || out_fire);
  assign load_s   = in_fire && |m_valid && !out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid   <= '0;
      s_valid   <= '0;
      s_full    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (|m_valid && !out_ready && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (flush) begin
        m_valid <= '0;
        s_valid <= '0;
        s_full  <= 1'b0;
      end else begin
        if (s_to_m) m_valid <= s_valid;
        else if (load_m) m_valid <= in_valid;
        else if (out_fire) m_valid <= '0;
        if (s_to_m) begin
          s_valid <= '0;
          s_full  <= 1'b0;
        end else if (load_s) begin
          s_valid <= in_valid;
          s_full  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s_to_m) begin
      m_d1  <= s_d1;
      m_d2  <= s_d2;
      m_pay <= s_pay;
    end else if (load_m) begin
      m_d1  <= d1_n;
      m_d2  <= d2_n;
      m_pay <= in_payload;
    end
    if (load_s) begin
      s_d1  <= d1_n;
      s_d2  <= d2_n;
      s_pay <= in_payload;
    end
  end

  assign out_valid   = m_valid;
  assign out_d1      = m_d1;
  assign out_d2      = m_d2;
  assign out_payload = m_pay;
endmodule

// File: tb/tb_operand_source_stage.sv
// tb_operand_source_stage: directed stimulus with a queue scoreboard checked by an independent monitor.
module tb_operand_source_stage;
  localparam int NCH = 8, XLEN = 64, PREG_W = 7, AREG_W = 5, NBYP = 4, PAY_W = 128;

  logic clk = 1'b0, resetn = 1'b0, flush = 1'b0, in_ready, out_ready = 1'b1;
  logic [NCH-1:0]         in_valid = '0, in_fwd1 = '0, in_fwd2 = '0, out_valid;
  logic [NCH*PREG_W-1:0]  in_psrc1 = '0, in_psrc2 = '0, prf_raddr1, prf_raddr2;
  logic [NCH*AREG_W-1:0]  in_asrc1 = '0, in_asrc2 = '0, arf_raddr1, arf_raddr2;
  logic [NCH*PAY_W-1:0]   in_payload = '0, out_payload;
  logic [NCH*XLEN-1:0]    prf_rdata1 = '0, prf_rdata2 = '0, arf_rdata1 = '0, arf_rdata2 = '0, out_d1, out_d2;
  logic [NBYP-1:0]        byp_valid = '0;
  logic [NBYP*PREG_W-1:0] byp_pdst = '0;
  logic [NBYP*XLEN-1:0]   byp_data = '0;
  logic [31:0]            stall_cnt;

  typedef struct packed {
    logic [7:0]   v;
    logic [63:0]  d1;
    logic [63:0]  d2;
    logic [127:0] pay;
  } exp_t;

  exp_t q[$];
  exp_t mon_got;
  int checks = 0, failures = 0;

  operand_source_stage dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_psrc1(in_psrc1), .in_psrc2(in_psrc2), .in_asrc1(in_asrc1), .in_asrc2(in_asrc2),
    .in_fwd1(in_fwd1), .in_fwd2(in_fwd2), .in_payload(in_payload),
    .prf_raddr1(prf_raddr1), .prf_raddr2(prf_raddr2), .prf_rdata1(prf_rdata1), .prf_rdata2(prf_rdata2),
    .arf_raddr1(arf_raddr1), .arf_raddr2(arf_raddr2), .arf_rdata1(arf_rdata1), .arf_rdata2(arf_rdata2),
    .byp_valid(byp_valid), .byp_pdst(byp_pdst), .byp_data(byp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_d1(out_d1), .out_d2(out_d2),
    .out_payload(out_payload), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [263:0] act, input logic [263:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A bundle is delivered on the edge following a negedge where out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (resetn && |out_valid && out_ready) begin
      mon_got = {out_valid, out_d1[63:0], out_d2[63:0], out_payload[127:0]};
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bundle: got %0h expected none", mon_got);
      end else check("out_bundle", mon_got, q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [7:0] v, input logic f1, input logic [6:0] ps1, input logic [4:0] as1,
                       input logic [63:0] prf1, input logic [63:0] arf1, input logic [63:0] e1,
                       input logic [127:0] pay, input logic exp_rdy);
    in_valid = v;
    in_fwd1 = '0;
    in_fwd1[0] = f1;
    in_psrc1 = '0;
    in_psrc1[6:0] = ps1;
    in_asrc1 = '0;
    in_asrc1[4:0] = as1;
    prf_rdata1 = '0;
    prf_rdata1[63:0] = prf1;
    arf_rdata1 = '0;
    arf_rdata1[63:0] = arf1;
    in_payload = '0;
    in_payload[127:0] = pay;
    @(negedge clk);
    check("in_ready_at_issue", in_ready, exp_rdy);
    if (exp_rdy && |v && !flush) q.push_back({v, e1, 64'h22, pay});
    @(posedge clk);
    #1;
    in_valid = '0;
  endtask

  initial begin
    in_asrc2[4:0] = 5'd5;
    arf_rdata2[63:0] = 64'h22;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick(1);

    // unstalled back-to-back stream from the ARF
    for (int i = 0; i < 3; i++) issue(8'h01, 1'b0, 7'd0, 5'd3, 64'h0, 64'h11, 64'h11, 128'(i + 1), 1'b1);
    check("stream_out_valid", out_valid, 8'h01);
    tick(2);

    // bypass priority and x0 handling
    byp_valid = 4'b0101;
    byp_pdst[6:0] = 7'd9;
    byp_pdst[13:7] = 7'd9;
    byp_pdst[20:14] = 7'd9;
    byp_data[63:0] = 64'h55;
    byp_data[127:64] = 64'h66;
    byp_data[191:128] = 64'h77;
    issue(8'h01, 1'b1, 7'd9, 5'd3, 64'hAA, 64'h11, 64'h55, 128'h10, 1'b1);
    issue(8'h01, 1'b0, 7'd9, 5'd3, 64'hAA, 64'h11, 64'h11, 128'h11, 1'b1);
    byp_valid = 4'b0000;
    issue(8'h01, 1'b1, 7'd9, 5'd3, 64'hAA, 64'h11, 64'hAA, 128'h12, 1'b1);
    byp_valid = 4'b0101;
    byp_pdst[6:0] = 7'd0;
    issue(8'h01, 1'b1, 7'd0, 5'd3, 64'hAA, 64'h11, 64'h0, 128'h13, 1'b1);
    issue(8'h01, 1'b0, 7'd9, 5'd0, 64'hAA, 64'h99, 64'h0, 128'h14, 1'b1);
    byp_valid = 4'b0000;
    tick(2);

    // back-pressure: A in main, B in skid, C refused
    out_ready = 1'b0;
    issue(8'h01, 1'b0, 7'd0, 5'd3, 64'h0, 64'hA1, 64'hA1, 128'hA, 1'b1);
    issue(8'h01, 1'b0, 7'd0, 5'd3, 64'h0, 64'hB1, 64'hB1, 128'hB, 1'b1);
    check("bp_in_ready", in_ready, 0);
    check("bp_stall_1", stall_cnt, 1);
    issue(8'h01, 1'b0, 7'd0, 5'd3, 64'h0, 64'hC1, 64'hC1, 128'hC, 1'b0);
    tick(3);
    check("bp_stall_5", stall_cnt, 5);
    out_ready = 1'b1;
    tick(1);
    check("bp_ready_after_drain", in_ready, 1);
    check("bp_b_in_main", out_valid, 8'h01);
    check("bp_stall_hold", stall_cnt, 5);
    tick(1);
    check("bp_empty", out_valid, 0);

    // flush while both entries are full, with an incoming bundle
    out_ready = 1'b0;
    issue(8'h01, 1'b0, 7'd0, 5'd3, 64'h0, 64'hD1, 64'hD1, 128'hD, 1'b1);
    issue(8'h01, 1'b0, 7'd0, 5'd3, 64'h0, 64'hE1, 64'hE1, 128'hE, 1'b1);
    flush = 1'b1;
    issue(8'h01, 1'b0, 7'd0, 5'd3, 64'h0, 64'hC2, 64'hC2, 128'hC2, 1'b0);
    flush = 1'b0;
    q.delete();
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_stall", stall_cnt, 6);
    out_ready = 1'b1;
    tick(3);

    // sparse bundle, then an all-empty bundle that must not be accepted
    issue(8'h05, 1'b0, 7'd0, 5'd3, 64'h0, 64'h11, 64'h11, 128'h5, 1'b1);
    issue(8'h00, 1'b0, 7'd0, 5'd3, 64'h0, 64'h11, 64'h11, 128'h6, 1'b1);
    tick(3);

    // asynchronous reset while stalled and full
    out_ready = 1'b0;
    issue(8'h01, 1'b0, 7'd0, 5'd3, 64'h0, 64'hF1, 64'hF1, 128'hF, 1'b1);
    issue(8'h01, 1'b0, 7'd0, 5'd3, 64'h0, 64'hF2, 64'hF2, 128'hF2, 1'b1);
    check("pre_reset_stall", stall_cnt, 7);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_stall", stall_cnt, 0);
    check("async_rst_in_ready", in_ready, 1);
    q.delete();
    @(negedge clk);
    resetn = 1'b1;
    out_ready = 1'b1;
    tick(1);
    issue(8'h01, 1'b0, 7'd0, 5'd7, 64'h0, 64'h77, 64'h77, 128'h77, 1'b1);
    for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
    check("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
